// File: rtl/count_pwm_if.sv
// Bus bundle for count_pwm_gen: counter sample, control and duty inputs,
// PWM/status outputs. The design sits on the slave modport.
interface count_pwm_if #(
   parameter int WIDTH    = 8,
   parameter int DT_WIDTH = 4
);
   logic [WIDTH-1:0]    count_i;
   logic                en_i;
   logic                mode_i;
   logic [WIDTH-1:0]    duty_i;
   logic                duty_we;
   logic [DT_WIDTH-1:0] deadtime_i;
   logic                pwm_o;
   logic                pwm_n_o;
   logic                period_o;
   logic                match_o;
   logic                busy_o;
   logic [7:0]          wrap_cnt_o;

   modport master (
      output count_i, en_i, mode_i, duty_i, duty_we, deadtime_i,
      input  pwm_o, pwm_n_o, period_o, match_o, busy_o, wrap_cnt_o
   );

   modport slave (
      input  count_i, en_i, mode_i, duty_i, duty_we, deadtime_i,
      output pwm_o, pwm_n_o, period_o, match_o, busy_o, wrap_cnt_o
   );
endinterface

// File: rtl/count_pwm_gen.sv
// Compare/PWM stage following an 8-bit up-counter: period detection, double-buffered
// duty, continuous/one-shot FSM. Define PWM_DEADTIME_EN for the dead-time complementary output.
module count_pwm_gen #(
   parameter int WIDTH    = 8,
   parameter int DT_WIDTH = 4
) (
   input logic        clk,
   input logic        reset,
   count_pwm_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
   logic [WIDTH-1:0] duty_act_q, duty_act_d;
   logic [WIDTH-1:0] duty_eff;
   logic             oneshot_q, oneshot_d;
   logic [7:0]       wrap_cnt_q, wrap_cnt_d;
   logic             pwm_q, pwm_d;
   logic             pwm_n_q, pwm_n_d;
   logic             period_q, period_d;
   logic             match_q, match_d;
   logic             busy_q, busy_d;
   logic             wrap, act, r;

   // A wrap is any step downward: natural rollover or a reload to a lower value.
   always_comb begin
      count_d    = bus.count_i;
      wrap       = bus.count_i < count_q;
      duty_eff   = wrap ? duty_sh_q : duty_act_q;
      duty_sh_d  = bus.duty_we ? bus.duty_i : duty_sh_q;
      duty_act_d = wrap ? duty_sh_q : duty_act_q;
      act        = bus.en_i && (((state_q == RUN) && !(oneshot_q && wrap)) ||
                                ((state_q == SYNC) && wrap));
      r          = act && (bus.count_i < duty_eff);
      match_d    = act && (duty_eff != '0) && (bus.count_i == duty_eff);
      period_d   = wrap && bus.en_i && ((state_q == SYNC) || (state_q == RUN));
   end

   always_comb begin
      state_d    = state_q;
      oneshot_d  = oneshot_q;
      wrap_cnt_d = wrap_cnt_q;
      if (!bus.en_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = SYNC;
               oneshot_d  = bus.mode_i;
               wrap_cnt_d = '0;
            end
            SYNC: if (wrap) state_d = RUN;
            RUN: begin
               if (wrap) begin
                  wrap_cnt_d = wrap_cnt_q + 8'd1;
                  if (oneshot_q) state_d = DONE;
               end
            end
            default: state_d = state_q;
         endcase
      end
      busy_d = (state_d == SYNC) || (state_d == RUN);
   end

`ifdef PWM_DEADTIME_EN
   localparam int RUN_W = DT_WIDTH + 1;

   logic             lvl_q, lvl_d;
   logic [RUN_W-1:0] lvl_run_q, lvl_run_d;

   function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
      return (&v) ? v : v + RUN_W'(1);
   endfunction

   // lvl_run counts consecutive active cycles (current included) at the present level of r.
   always_comb begin
      lvl_d = r;
      if (!act)
         lvl_run_d = '0;
      else if (r == lvl_q)
         lvl_run_d = sat_inc(lvl_run_q);
      else
         lvl_run_d = RUN_W'(1);
      pwm_d   = r && (lvl_run_d > {1'b0, bus.deadtime_i});
      pwm_n_d = act && !r && (lvl_run_d > {1'b0, bus.deadtime_i});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_q     <= 1'b0;
         lvl_run_q <= '0;
      end else begin
         lvl_q     <= lvl_d;
         lvl_run_q <= lvl_run_d;
      end
   end
`else
   always_comb begin
      pwm_d   = r;
      pwm_n_d = 1'b0;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         duty_sh_q  <= '0;
         duty_act_q <= '0;
         oneshot_q  <= 1'b0;
         wrap_cnt_q <= '0;
         pwm_q      <= 1'b0;
         pwm_n_q    <= 1'b0;
         period_q   <= 1'b0;
         match_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         duty_sh_q  <= duty_sh_d;
         duty_act_q <= duty_act_d;
         oneshot_q  <= oneshot_d;
         wrap_cnt_q <= wrap_cnt_d;
         pwm_q      <= pwm_d;
         pwm_n_q    <= pwm_n_d;
         period_q   <= period_d;
         match_q    <= match_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.pwm_o      = pwm_q;
   assign bus.pwm_n_o    = pwm_n_q;
   assign bus.period_o   = period_q;
   assign bus.match_o    = match_q;
   assign bus.busy_o     = busy_q;
   assign bus.wrap_cnt_o = wrap_cnt_q;
endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed and randomized bench for count_pwm_gen against a cycle-level reference
// model built from the period/duty/mode rules and consecutive-level run lengths.
module tb_count_pwm_gen;
   localparam int WIDTH    = 8;
   localparam int DT_WIDTH = 4;
   localparam int DT       = 3;
   localparam int S_IDLE = 0, S_SYNC = 1, S_RUN = 2, S_DONE = 3;

   logic clk = 1'b0;
   logic reset;

   count_pwm_if #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) bus ();
   count_pwm_gen #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_prev, m_sh, m_act, m_st, m_os, m_wc, m_hi, m_lo;
   logic e_pwm, e_pwmn, e_per, e_match, e_busy;
   int e_wc;
   int t_pwm, t_pwmn, t_match, t_per;
   int cur;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_hi(input int d);
`ifdef PWM_DEADTIME_EN
      return (d > DT) ? d - DT : 0;
`else
      return d;
`endif
   endfunction

   function automatic int exp_lo(input int d);
`ifdef PWM_DEADTIME_EN
      return (256 - d > DT) ? 256 - d - DT : 0;
`else
      return 0 * d;
`endif
   endfunction

   task automatic model_reset();
      m_prev = 0; m_sh = 0; m_act = 0; m_st = S_IDLE; m_os = 0; m_wc = 0;
      m_hi = 0; m_lo = 0;
      e_pwm = 0; e_pwmn = 0; e_per = 0; e_match = 0; e_busy = 0; e_wc = 0;
   endtask

   task automatic model_step();
      int c, eff, nst, dt;
      bit wrap, act, r, en;
      c    = int'(bus.count_i);
      en   = bus.en_i;
      dt   = int'(bus.deadtime_i);
      wrap = (c < m_prev);
      eff  = wrap ? m_sh : m_act;
      act  = en && ((m_st == S_RUN && !(m_os != 0 && wrap)) || (m_st == S_SYNC && wrap));
      r    = act && (c < eff);
      e_match = act && (eff != 0) && (c == eff);
      e_per   = wrap && en && (m_st == S_SYNC || m_st == S_RUN);
      if (r) begin m_hi++; m_lo = 0; end
      else if (act) begin m_lo++; m_hi = 0; end
      else begin m_hi = 0; m_lo = 0; end
`ifdef PWM_DEADTIME_EN
      e_pwm  = r && (m_hi > dt);
      e_pwmn = act && !r && (m_lo > dt);
`else
      e_pwm  = r;
      e_pwmn = 1'b0;
      dt     = 0;
`endif
      nst = m_st;
      if (!en) nst = S_IDLE;
      else begin
         case (m_st)
            S_IDLE: begin nst = S_SYNC; m_os = int'(bus.mode_i); m_wc = 0; end
            S_SYNC: if (wrap) nst = S_RUN;
            S_RUN:  if (wrap) begin m_wc = (m_wc + 1) % 256; if (m_os != 0) nst = S_DONE; end
            S_DONE: nst = S_DONE;
            default: nst = m_st;
         endcase
      end
      m_st   = nst;
      e_busy = (nst == S_SYNC) || (nst == S_RUN);
      e_wc   = m_wc;
      if (wrap) m_act = m_sh;
      if (bus.duty_we) m_sh = int'(bus.duty_i);
      m_prev = c;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("pwm_o",      bus.pwm_o,      e_pwm);
      chk("pwm_n_o",    bus.pwm_n_o,    e_pwmn);
      chk("period_o",   bus.period_o,   e_per);
      chk("match_o",    bus.match_o,    e_match);
      chk("busy_o",     bus.busy_o,     e_busy);
      chk("wrap_cnt_o", bus.wrap_cnt_o, e_wc);
      t_pwm   += int'(bus.pwm_o);
      t_pwmn  += int'(bus.pwm_n_o);
      t_match += int'(bus.match_o);
      t_per   += int'(bus.period_o);
      bus.duty_we = 1'b0;
   endtask

   task automatic set_cnt(input int c);
      cur = c % 256;
      bus.count_i = cur[7:0];
   endtask

   task automatic run_counts(input int from, input int to);
      for (int c = from; c <= to; c++) begin
         set_cnt(c);
         tick();
      end
   endtask

   task automatic run_period(input int we_at, input int we_val);
      t_pwm = 0; t_pwmn = 0; t_match = 0; t_per = 0;
      for (int c = 0; c < 256; c++) begin
         set_cnt(c);
         if (c == we_at) begin
            bus.duty_i  = we_val[7:0];
            bus.duty_we = 1'b1;
         end
         tick();
      end
   endtask

   task automatic write_duty(input int v);
      bus.duty_i  = v[7:0];
      bus.duty_we = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " pwm_o"},      bus.pwm_o,      0);
      chk({tag, " pwm_n_o"},    bus.pwm_n_o,    0);
      chk({tag, " period_o"},   bus.period_o,   0);
      chk({tag, " match_o"},    bus.match_o,    0);
      chk({tag, " busy_o"},     bus.busy_o,     0);
      chk({tag, " wrap_cnt_o"}, bus.wrap_cnt_o, 0);
   endtask

   initial begin
      reset = 1'b0;
      bus.count_i = '0; bus.en_i = 1'b0; bus.mode_i = 1'b0;
      bus.duty_i = '0; bus.duty_we = 1'b0; bus.deadtime_i = DT_WIDTH'(DT);
      cur = 0;
      t_pwm = 0; t_pwmn = 0; t_match = 0; t_per = 0;
      #2 reset = 1'b1;
      #2;
      model_reset();
      chk_all_zero("reset");
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;

      // continuous, duty 0x40
      write_duty(8'h40);
      set_cnt(0); tick();
      bus.en_i = 1'b1;
      run_counts(0, 255);
      run_period(-1, 0);
      chk("cont pwm high", t_pwm, exp_hi(8'h40));
      chk("cont pwm_n high", t_pwmn, exp_lo(8'h40));
      chk("cont match count", t_match, 1);
      chk("cont period count", t_per, 1);
      run_period(-1, 0);
      chk("cont wrap_cnt", bus.wrap_cnt_o, 1);

      // duty update mid-period and on the wrap cycle
      run_period(8'h20, 8'h80);
      chk("upd old period", t_pwm, exp_hi(8'h40));
      run_period(0, 8'h30);
      chk("upd new period", t_pwm, exp_hi(8'h80));
      run_period(-1, 0);
      chk("upd on wrap late", t_pwm, exp_hi(8'h30));

      // one-shot
      bus.en_i = 1'b0; bus.mode_i = 1'b1;
      write_duty(8'h10);
      set_cnt(0); tick();
      bus.en_i = 1'b1;
      run_counts(1, 255);
      run_period(-1, 0);
      chk("oneshot pulse", t_pwm, exp_hi(8'h10));
      run_period(-1, 0);
      chk("oneshot done pwm", t_pwm, 0);
      chk("oneshot done busy", bus.busy_o, 0);
      chk("oneshot wrap_cnt", bus.wrap_cnt_o, 1);
      bus.en_i = 1'b0;
      set_cnt(0); tick();
      bus.en_i = 1'b1;
      run_counts(1, 255);
      run_period(-1, 0);
      chk("oneshot second pulse", t_pwm, exp_hi(8'h10));

      // downward load
      bus.en_i = 1'b0; bus.mode_i = 1'b0;
      set_cnt(0); tick();
      bus.en_i = 1'b1;
      run_counts(1, 255);
      set_cnt(0); tick();
      run_counts(1, 8'h4F);
      write_duty(8'h20);
      run_counts(8'h50, 8'h90);
      set_cnt(8'h05); tick();
      chk("load period_o", bus.period_o, 1);
      chk("load wrap_cnt", bus.wrap_cnt_o, 1);
      run_counts(8'h06, 8'h1F);
      set_cnt(8'h20); tick();
      chk("load match_o", bus.match_o, 1);
      run_counts(8'h21, 8'hFF);

      // boundary duties
      run_period(8'h10, 8'h00);
      run_period(-1, 0);
      chk("duty0 pwm", t_pwm, 0);
      chk("duty0 match", t_match, 0);
      run_period(8'h10, 8'hFF);
      run_period(-1, 0);
      chk("dutyFF pwm", t_pwm, exp_hi(8'hFF));
      chk("dutyFF match", t_match, 1);

      // asynchronous reset mid-period
      run_counts(0, 8'h30);
      chk("pre-reset pwm_o", bus.pwm_o, 1);
      chk("pre-reset busy_o", bus.busy_o, 1);
      #2 reset = 1'b1;
      #1;
      chk_all_zero("async reset");
      model_reset();
      @(posedge clk); #1 reset = 1'b0;

      // randomized traffic
      bus.en_i = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         int rnd;
         rnd = int'($urandom_range(0, 99));
         if (rnd < 3) set_cnt(int'($urandom_range(0, 255)));
         else if (rnd >= 6) set_cnt(cur + 1);
         if ($urandom_range(0, 599) == 0) begin
            bus.en_i   = ~bus.en_i;
            bus.mode_i = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 29) == 0) begin
            rnd = int'($urandom_range(0, 9));
            write_duty(rnd == 0 ? 0 : (rnd == 1 ? 255 : int'($urandom_range(0, 255))));
         end
         if ($urandom_range(0, 499) == 0)
            bus.deadtime_i = DT_WIDTH'($urandom_range(0, 15));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/count_pwm_gen.md
# count_pwm_gen

Compare/PWM stage directly downstream of the 8-bit loadable up-counter. It samples the counter's 8-bit value each clock, detects period boundaries (wrap-around or downward load), and drives a PWM output from a double-buffered duty register. Continuous and one-shot modes are supported, with match and period-start pulses for the surrounding control logic. An optional complementary output with programmable dead-time is available.

## Interface
- `WIDTH`, 8: counter/duty width.
- `DT_WIDTH`, 4: dead-time counter width.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `count_i`  in  WIDTH  counter value, sampled every `clk`.
- `en_i`  in  1  level enable; low forces IDLE.
- `mode_i`  in  1  0 = continuous, 1 = one-shot; sampled on IDLE->SYNC.
- `duty_i`  in  WIDTH  new duty value.
- `duty_we`  in  1  writes `duty_i` into the shadow register.
- `deadtime_i`  in  DT_WIDTH  dead-time in cycles; used only with `PWM_DEADTIME_EN`.
- `pwm_o`  out  1  PWM output, registered.
- `pwm_n_o`  out  1  complementary output (see Configuration).
- `period_o`  out  1  one-cycle pulse on each detected period start while in SYNC or RUN.
- `match_o`  out  1  one-cycle pulse when `count_i` equals the effective duty in RUN.
- `busy_o`  out  1  high in SYNC or RUN.
- `wrap_cnt_o`  out  8  completed periods, modulo 256.

## Operation
- **Period detection.**
  - `count_q` holds the previous `count_i`.
  - `wrap = (count_i < count_q)`, unsigned compare. This covers 0xFF->0x00 and any downward load.
  - Equal or increasing values are not a wrap.
- **Duty double buffering.**
  - `duty_we` writes `duty_sh`.
  - On a wrap cycle, `duty_act <= duty_sh`.
  - `duty_eff = wrap ? duty_sh : duty_act` (the new duty applies from the wrap cycle onward).
  - If `duty_we` and `wrap` coincide, the old `duty_sh` transfers and the new value waits for the next period.
- **FSM states:** IDLE, SYNC, RUN, DONE.
  - IDLE: if `en_i`, go to SYNC, latch `mode_i`, and clear `wrap_cnt_o`.
  - SYNC: on `wrap`, go to RUN.
  - RUN, continuous: on `wrap`, stay in RUN and increment `wrap_cnt_o`.
  - RUN, one-shot: on `wrap`, go to DONE and increment `wrap_cnt_o`.
  - DONE: on `en_i` low, go to IDLE.
  - `en_i` low in any state goes to IDLE; this takes priority.
- **Active condition:** `act = (state==RUN && !(oneshot && wrap)) || (state==SYNC && wrap)`, with `en_i` high.
- **PWM:** `pwm_o <= act && (count_i < duty_eff)`.
  - Duty 0 gives constant low.
  - Duty 0xFF gives high for 255 of 256 counts.
- **Match:** `match_o <= act && duty_eff != 0 && count_i == duty_eff`.
- **Period:** `period_o <= wrap && en_i && state ∈ {SYNC, RUN}`.

## Timing
- All outputs are registered, with 1-cycle latency from `count_i` to `pwm_o`, `match_o` and `period_o`.
- Reset: state IDLE; `count_q`, `duty_sh`, `duty_act`, `wrap_cnt_o` = 0; `pwm_o`, `pwm_n_o`, `period_o`, `match_o`, `busy_o` = 0.
- `busy_o` is registered from the next state: it is high the cycle after `en_i` rises in IDLE, and low the cycle after `en_i` falls.
- `wrap_cnt_o` wraps 0xFF->0x00 silently.
- Reset asserted mid-period: all outputs drop low asynchronously. The first wrap after release is not detected until `count_q` is loaded.
- A counter held constant produces no wrap; SYNC waits indefinitely.

## Configuration
- **`PWM_DEADTIME_EN` defined:**
  - Raw signal `r` is the unregistered PWM term.
  - `pwm_o` rises only after `r` has been high for `deadtime_i` consecutive cycles.
  - `pwm_n_o` rises only after `r` has been low for `deadtime_i` consecutive cycles while active.
  - Each output falls in the cycle after its level of `r` ends.
  - Pulses shorter than `deadtime_i` are suppressed.
  - `deadtime_i`=0 gives `pwm_n_o` = `act && !r`, registered.
  - Both outputs are low when not active.
- **`PWM_DEADTIME_EN` undefined:** `pwm_n_o` is tied 0, `deadtime_i` is ignored, and no dead-time counter is present.

## Test plan
- Continuous, duty 0x40: counter free-runs from 0x00 with `en_i`=1. Expect `period_o` at each 0xFF->0x00 after SYNC; `pwm_o` high for 64 cycles per 256; `match_o` once per period; `wrap_cnt_o` 0,1,2,...
- Duty update mid-period: write 0x80 at count 0x20 with duty 0x40. The current period stays 64 high; the next period is 128 high. `duty_we` on the wrap cycle itself takes effect one period later.
- One-shot: `mode_i`=1, duty 0x10. Expect exactly one 16-cycle pulse, then DONE with `busy_o`=0 and `wrap_cnt_o`=1. Drop `en_i` and raise it again: a second pulse follows.
- Downward load: counter reloaded from 0x90 to 0x05. Expect `period_o` pulse and duty shadow transfer; `pwm_o` follows the new period.
- Boundaries: duty 0 gives `pwm_o` always 0 and no `match_o`. Duty 0xFF gives 255-high/1-low. Reset asserted at count 0x30 gives all outputs 0 immediately.
- Dead-time (with `PWM_DEADTIME_EN`): `deadtime_i`=3, duty 0x40. Expect `pwm_o` high for 61 cycles and `pwm_n_o` high for 189, with both low for 3 cycles at each transition. Duty 0x02 gives `pwm_o` never high.
